// File: rtl/mazegen_bt_if.sv
// mazegen_bt_if: control, status and row-read port bundle for mazegen_bt
// master: start/seed/mode/rd_row out, busy/done/rd_data in; slave is the mirror
interface mazegen_bt_if #(
  parameter int W = 15,
  parameter int H = 15,
  parameter int RW = $clog2(H)
);
  logic start;
  logic [15:0] seed;
  logic [1:0] mode;
  logic busy;
  logic done;
  logic [RW-1:0] rd_row;
  logic [W-1:0] rd_data;
  modport master (output start, seed, mode, rd_row, input busy, done, rd_data);
  modport slave (input start, seed, mode, rd_row, output busy, done, rd_data);
endinterface

// File: rtl/mazegen_bt.sv
// mazegen_bt: binary-tree maze generator over an H x W wall bitmap with registered row readback
// clk: clock; rst: async active-low reset
// bus.start/seed/mode: launch request, LFSR seed, carve bias (sampled in IDLE/DONE)
// bus.busy/done: generation running / maze complete; bus.rd_row -> bus.rd_data one cycle later
module mazegen_bt #(
  parameter int W = 15,
  parameter int H = 15,
  parameter int RW = $clog2(H)
) (
  input logic clk,
  input logic rst,
  mazegen_bt_if.slave bus
);
  localparam int CB = $clog2(W);
  localparam logic [RW-1:0] RLAST = RW'(H - 1);
  localparam logic [RW-1:0] CRLAST = RW'(H - 2);
  localparam logic [CB-1:0] CCLAST = CB'(W - 2);
  typedef enum logic [2:0] {IDLE, INIT, CARVE, FINISH, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] mem [H];
  logic [RW-1:0] r, vr;
  logic [CB-1:0] c, hc;
  logic [15:0] lfsr;
  logic [1:0] mode;
  logic accept, north, west, vb, hb, vcut, hcut;
  assign accept = (state == IDLE || state == DONE) && bus.start;
  assign bus.busy = state == INIT || state == CARVE || state == FINISH;
  assign bus.done = state == DONE;
  // r/c hold the bitmap position of the current cell (always odd) during CARVE
  assign north = !mode[1];
  assign west = !mode[0];
  assign vb = north ? r == RW'(1) : r == CRLAST;
  assign hb = west ? c == CB'(1) : c == CCLAST;
  assign vcut = !vb && (hb || lfsr[0]);
  assign hcut = !hb && !vcut;
  assign vr = north ? r - RW'(1) : r + RW'(1);
  assign hc = west ? c - CB'(1) : c + CB'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = INIT;
    else if (state == INIT && r == RLAST) state_nx = CARVE;
    else if (state == CARVE && r == CRLAST && c == CCLAST) state_nx = FINISH;
    else if (state == FINISH) state_nx = DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r <= '0;
      c <= '0;
      lfsr <= 16'h0001;
      mode <= '0;
      bus.rd_data <= '0;
      for (int i = 0; i < H; i++) mem[i] <= '1;
    end else begin
      bus.rd_data <= bus.rd_row < RW'(H) ? mem[bus.rd_row] : '0;
      if (accept) begin
        lfsr <= bus.seed == 16'h0 ? 16'h0001 : bus.seed;
        mode <= bus.mode;
        r <= '0;
      end else if (state == INIT) begin
        mem[r] <= '1;
        r <= r == RLAST ? RW'(1) : r + RW'(1);
        c <= CB'(1);
      end else if (state == CARVE) begin
        mem[r][c] <= 1'b0;
        if (vcut) mem[vr][c] <= 1'b0;
        if (hcut) mem[r][hc] <= 1'b0;
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        c <= c == CCLAST ? CB'(1) : c + CB'(2);
        if (c == CCLAST) r <= r + RW'(2);
      end else if (state == FINISH) begin
        mem[RW'(0)][CB'(1)] <= 1'b0;
        mem[RLAST][CCLAST] <= 1'b0;
      end
    end
endmodule
